// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module uart_fifo_ram #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with per-entry error flags and a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH,
  localparam int unsigned PtrW     = $clog2(DEPTH),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_parity_err,
  input  logic                 in_frame_err,
  input  logic                 in_ready_lvl,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_parity_err,
  output logic                 rd_frame_err,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [CntW-1:0]      count,
  output logic                 full,
  output logic                 empty,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  // Same field layout as uart_rx_entry_t, sized by this instance's DATA_BITS.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } entry_t;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready_q, overrun_q, overrun_d;
  logic            wr_fire, rd_fire, wr_en, drop;
  entry_t          wr_entry, rd_entry;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign rd_valid = ~empty;
  assign count    = count_q;
  assign overrun  = overrun_q;

  // Receiver holds data_ready for a whole tick period; capture on its rising edge only.
  assign wr_fire = in_ready_lvl & ~in_ready_q;
  assign rd_fire = rd_valid & rd_ready;
  // When full, a simultaneous read frees the head slot, which is the slot being written.
  assign wr_en   = wr_fire & (~full | rd_fire);
  assign drop    = wr_fire & full & ~rd_fire;

  assign wr_entry = '{data: in_data, parity_err: in_parity_err, frame_err: in_frame_err};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_lvl;
      overrun_q  <= overrun_d;
    end
  end

  uart_fifo_ram #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(wr_entry),
    .raddr(rd_ptr_q),
    .rdata(rd_entry)
  );

  assign rd_data       = rd_entry.data;
  assign rd_parity_err = rd_entry.parity_err;
  assign rd_frame_err  = rd_entry.frame_err;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. It captures each completed character together with its parity and framing error flags, and holds the characters in a first-word-fall-through FIFO. It presents them to the bus/host side over a valid/ready handshake. It also reports fill level and a sticky overrun flag, so the host can drain characters at its own pace without losing error information.

Parameters:
- DATA_BITS, 8, character width; must match the receiver's DATA_BITS.
- DEPTH, 16, number of entries; power of 2 and at least 2, otherwise $fatal at elaboration.

Ports:
- clk  input  1  system clock; the same clock as the receiver.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_BITS  character from the receiver (its rx_data).
- in_parity_err  input  1  parity error flag for in_data.
- in_frame_err  input  1  framing error flag for in_data.
- in_ready_lvl  input  1  receiver's data_ready; a level that may stay high for many clk cycles (one tick_16x period).
- rd_data  output  DATA_BITS  head-of-FIFO character.
- rd_parity_err  output  1  head entry's parity flag.
- rd_frame_err  output  1  head entry's framing flag.
- rd_valid  output  1  FIFO non-empty; the head entry is valid.
- rd_ready  input  1  consumer accepts the head entry.
- count  output  $clog2(DEPTH)+1  current number of entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overrun  output  1  sticky: a character was dropped because the FIFO was full.
- overrun_clr  input  1  single-cycle clear of overrun.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; empty=1, full=0, rd_valid=0, overrun=0.
  - The edge-detect register is cleared to 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately.
- Write strobe:
  - wr_fire = in_ready_lvl & ~in_ready_q, where in_ready_q is in_ready_lvl registered on clk.
  - Exactly one capture happens per receiver data_ready assertion, however long the level is held.
- Entry: {in_data, in_parity_err, in_frame_err} packed as one uart_rx_entry_t; all three fields are captured in the same cycle as wr_fire.
- Read: rd_fire = rd_valid & rd_ready.
  - rd_data and the flags are driven combinationally from mem[rd_ptr] (FWFT).
  - rd_ptr advances on rd_fire.
- Latency: a write into an empty FIFO gives rd_valid=1 on the clk edge after wr_fire; the data is stable while rd_valid=1 and rd_ready=0.
- Pointers: $clog2(DEPTH) bits each, natural wrap-around modulo DEPTH.
- count changes per cycle:
  - +1 on accepted write only;
  - −1 on read only;
  - unchanged when both occur or neither occurs.
- Simultaneous events:
  - Full, wr_fire and rd_fire together: the write is accepted, the read is performed, count stays DEPTH, no overrun.
  - Empty, wr_fire and rd_ready together: no read (rd_valid=0); the write is accepted.
  - Full, wr_fire and no rd_fire: the character is dropped, overrun is set on the next edge, and storage and pointers are unchanged.
  - overrun_clr in the same cycle as a new overrun event: set wins, overrun stays 1.
- rd_ready while empty is ignored; no underflow, pointers are unchanged.
- Error flags are carried per entry only; the FIFO never alters or merges them.
- No state machine beyond the pointer/count logic and the edge detector; all registers update every clk; no dependence on tick_16x.

Decomposition:
- uart_pkg holds:
  - typedef uart_rx_entry_t, a packed struct {data [DATA_BITS-1:0], parity_err, frame_err}; the package parameter UART_DATA_BITS=8 sets the default width.
  - localparam UART_RX_FIFO_DEPTH=16.
- Sub-module uart_fifo_ram: simple dual-port storage, with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata), parameterised by WIDTH and DEPTH. The top level holds the pointers, count, edge detect and overrun.

Test Plan:
1. After reset, drive in_ready_lvl high for 16 clk with in_data=0xA5 and flags 0,0 → exactly one entry: count=1, rd_valid=1, rd_data=0xA5, both flags 0.
2. Write 0x11 with parity_err=1, then 0x22 with frame_err=1; hold rd_ready=1 → reads 0x11/parity=1/frame=0, then 0x22/parity=0/frame=1; ends empty=1, count=0.
3. Write 16 bytes 0x00..0x0F with no reads → full=1, count=16. A 17th write of 0xFF → overrun=1, count stays 16, and reads return 0x00..0x0F in order with 0xFF absent.
4. Full FIFO, wr_fire of 0x55 in the same cycle as rd_fire → count stays 16, overrun=0, and 0x55 is read last after 15 more reads.
5. overrun=1, pulse overrun_clr alone → overrun=0. Then assert overrun_clr on the same cycle as a new dropped write → overrun=1.
6. With 5 entries and rd_ready toggling, assert reset_n low mid-read for 1 cycle → count=0, empty=1, rd_valid=0, overrun=0. The next write of 0x3C reads back as 0x3C, confirming the pointers restarted at 0.
